vector_ls_sequencer: RTL and testbench
======================================

VECTOR_LS_SEQUENCER -- requirements
Module: vector_ls_sequencer

Interface
REQ-001 Parameter NUM_SLICES, default 1, number of vector slices served.
REQ-002 Parameter NUM_ELEMS, default 8, elements per vector.
REQ-003 Parameter ELEM_SIZE, default 16, element width in bits.
REQ-004 Parameter SCALAR_SIZE, default 32, scalar word width in bits.
REQ-005 Derived constants SHALL be: SPV = NUM_ELEMS*ELEM_SIZE/SCALAR_SIZE; NSC = SPV*NUM_SLICES; EPW = SCALAR_SIZE/ELEM_SIZE.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 ls  Vector_ls_ctrl_if.shared  -  responder end of the vector load/store control interface; its members are listed in REQ-009 to REQ-016.
REQ-009 ls.new_op  input  1  single-cycle operation start strobe from the controller.
REQ-010 ls.count  input  clog2(NSC)+1  number of scalar words to transfer.
REQ-011 ls.we  input  1  1 = load (scalar to vector), 0 = store (vector to scalar).
REQ-012 ls.g  input  Pu_types::Word  start scalar index; only the low clog2(NSC) bits are used.
REQ-013 ls.load_en  output  NUM_ELEMS x 1  per-element write enable.
REQ-014 ls.sel_word, ls.sel_store_word  output  clog2(SPV)  word within the slice for the current load beat and store beat.
REQ-015 ls.serial_output  output  NUM_SLICES x 1  one-hot active-slice select.
REQ-016 ls.complete  output  1  single-cycle end-of-operation pulse.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-018 In IDLE or DONE, new_op=1 SHALL latch count, we and g[clog2(NSC)-1:0], and set the word index idx to g mod NSC.
REQ-019 On that accept, the FSM SHALL go to RUN if count>0, otherwise to DONE.
REQ-020 A latched count greater than NSC SHALL be clamped to NSC.
REQ-021 In RUN, the block SHALL issue one beat per cycle.
- slice = idx / SPV; word = idx mod SPV.
- serial_output[slice] = 1 and all other bits 0.
REQ-022 A load beat (we=1) SHALL drive sel_word = word and load_en[e] = 1 exactly for e in [word*EPW, word*EPW+EPW-1].
- sel_store_word SHALL hold 0 during load beats.
REQ-023 A store beat (we=0) SHALL drive sel_store_word = word and hold all load_en at 0.
- sel_word SHALL hold 0 during store beats.
REQ-024 After each beat, idx SHALL increment and wrap from NSC-1 to 0, and the remaining count SHALL decrement.
REQ-025 The beat that brings the remaining count to 0 SHALL move the FSM to DONE.
REQ-026 In DONE, complete SHALL be 1 for exactly one cycle.
- The next state is IDLE, or a new accept per REQ-018/REQ-019.
REQ-027 Latency: new_op at edge N gives the first beat in cycle N+1, the last beat in cycle N+count, and complete in cycle N+count+1.
- For count=0, complete is in cycle N+1.
REQ-028 new_op during RUN SHALL be ignored, with no effect on the latched values or the beat sequence.
REQ-029 Outside RUN, load_en, serial_output, sel_word and sel_store_word SHALL all be 0.
REQ-030 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-031 reset=0 SHALL immediately force state IDLE, idx=0 and remaining count=0, with every output at 0.
REQ-032 Reset during RUN SHALL abort the operation with no complete pulse; the first accept after reset is release starts cleanly.

Structure
REQ-033 The state enum, the SPV/NSC/EPW computation and the index width SHALL live in the shared package Vector_ls_pkg.
REQ-034 Index decoding (idx and we to load_en, sel_word, sel_store_word, serial_output) SHALL be the combinational sub-module vector_ls_index_decode.
- Its results SHALL be registered in vector_ls_sequencer.

Verification
Bench parameters for all scenarios: NUM_SLICES=2, defaults otherwise, so SPV=4, NSC=8, EPW=2.
REQ-035 Load test: new_op, we=1, count=3, g=0 -> beats in cycles 1-3.
- sel_word = 0, 1, 2; load_en = {0,1}, {2,3}, {4,5}; serial_output = 01.
- complete in cycle 4.
REQ-036 Store wrap test: new_op, we=0, count=4, g=6 -> idx = 6, 7, 0, 1.
- sel_store_word = 2, 3, 0, 1; serial_output = 10, 10, 01, 01; load_en always 0.
REQ-037 Zero-count test: new_op, count=0 -> no beats; complete 1 cycle after new_op.
REQ-038 Clamp and ignore test: count=12 -> exactly 8 beats.
- A new_op pulsed in beat 3 with count=1 is ignored: still 8 beats total and one complete.
REQ-039 Back-to-back test: new_op in the DONE cycle with count=2 -> beats start in the next cycle, with no IDLE gap.
REQ-040 Reset test: reset asserted in beat 2 of a count=5 load -> outputs 0 asynchronously and no complete pulse.
- After release, a count=1 operation completes normally.

Source files
------------

// File: rtl/Pu_types.sv
// Shared processing-unit scalar types.
package Pu_types;

    typedef logic [31:0] Word;

endpackage

// File: rtl/Vector_ls_pkg.sv
// Vector load/store sequencer: FSM states and derived geometry helpers.
package Vector_ls_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ls_state_e;

    // Scalar words per vector slice.
    function automatic int calc_spv(input int num_elems, input int elem_size, input int scalar_size);
        return num_elems * elem_size / scalar_size;
    endfunction

    // Scalar words across all slices.
    function automatic int calc_nsc(input int spv, input int num_slices);
        return spv * num_slices;
    endfunction

    // Elements packed in one scalar word.
    function automatic int calc_epw(input int elem_size, input int scalar_size);
        return scalar_size / elem_size;
    endfunction

    // Index width, never below one bit so single-entry ranges still have a port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/Vector_ls_ctrl_if.sv
// Control interface between the vector load/store controller and the sequencer.
interface Vector_ls_ctrl_if #(
    parameter int NUM_SLICES  = 1,
    parameter int NUM_ELEMS   = 8,
    parameter int ELEM_SIZE   = 16,
    parameter int SCALAR_SIZE = 32
);
    localparam int SPV = Vector_ls_pkg::calc_spv(NUM_ELEMS, ELEM_SIZE, SCALAR_SIZE);
    localparam int NSC = Vector_ls_pkg::calc_nsc(SPV, NUM_SLICES);
    localparam int CW  = $clog2(NSC) + 1;
    localparam int WW  = Vector_ls_pkg::idx_width(SPV);

    logic                  new_op;
    logic [CW-1:0]         count;
    logic                  we;
    Pu_types::Word         g;
    logic [NUM_ELEMS-1:0]  load_en;
    logic [WW-1:0]         sel_word;
    logic [WW-1:0]         sel_store_word;
    logic [NUM_SLICES-1:0] serial_output;
    logic                  complete;

    modport shared (
        input  new_op, count, we, g,
        output load_en, sel_word, sel_store_word, serial_output, complete
    );

    modport ctrl (
        output new_op, count, we, g,
        input  load_en, sel_word, sel_store_word, serial_output, complete
    );

endinterface

// File: rtl/vector_ls_index_decode.sv
// Combinational decode of a flat word index into slice/word selects and element enables.
module vector_ls_index_decode
    import Vector_ls_pkg::*;
#(
    parameter int NUM_SLICES  = 1,
    parameter int NUM_ELEMS   = 8,
    parameter int ELEM_SIZE   = 16,
    parameter int SCALAR_SIZE = 32
) (
    input  logic [idx_width(calc_nsc(calc_spv(NUM_ELEMS, ELEM_SIZE, SCALAR_SIZE), NUM_SLICES))-1:0] idx,
    input  logic                  we,
    input  logic                  active,
    output logic [NUM_ELEMS-1:0]  load_en,
    output logic [idx_width(calc_spv(NUM_ELEMS, ELEM_SIZE, SCALAR_SIZE))-1:0] sel_word,
    output logic [idx_width(calc_spv(NUM_ELEMS, ELEM_SIZE, SCALAR_SIZE))-1:0] sel_store_word,
    output logic [NUM_SLICES-1:0] serial_output
);
    localparam int SPV = calc_spv(NUM_ELEMS, ELEM_SIZE, SCALAR_SIZE);
    localparam int EPW = calc_epw(ELEM_SIZE, SCALAR_SIZE);
    localparam int WW  = idx_width(SPV);

    // Word within the slice; the arithmetic is done at 32 bits so a power-of-two
    // SPV never truncates to a zero divisor.
    logic [WW-1:0] word;
    assign word = WW'(32'(idx) % SPV);

    // Only one of the two word selects is live per beat; the other stays 0.
    assign sel_word       = (active &&  we) ? word : '0;
    assign sel_store_word = (active && !we) ? word : '0;

    // Each element is enabled when its owning scalar word is the current one.
    for (genvar e = 0; e < NUM_ELEMS; e++) begin : g_elem
        assign load_en[e] = active && we && ((32'(idx) % SPV) == (e / EPW));
    end

    // One-hot select of the slice holding the current word.
    for (genvar s = 0; s < NUM_SLICES; s++) begin : g_slice
        assign serial_output[s] = active && ((32'(idx) / SPV) == s);
    end

endmodule

// File: rtl/vector_ls_sequencer.sv
// Vector load/store sequencer: walks a run of scalar words across the vector
// slices, one beat per cycle, and pulses complete when the run is over.
module vector_ls_sequencer
    import Vector_ls_pkg::*;
#(
    parameter int NUM_SLICES  = 1,
    parameter int NUM_ELEMS   = 8,
    parameter int ELEM_SIZE   = 16,
    parameter int SCALAR_SIZE = 32
) (
    input  logic             clk,
    input  logic             reset,
    Vector_ls_ctrl_if.shared ls
);
    localparam int SPV = calc_spv(NUM_ELEMS, ELEM_SIZE, SCALAR_SIZE);
    localparam int NSC = calc_nsc(SPV, NUM_SLICES);
    localparam int IW  = idx_width(NSC);
    localparam int WW  = idx_width(SPV);
    localparam int CW  = $clog2(NSC) + 1;

    ls_state_e     state_q, state_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic [CW-1:0] rem_q,   rem_d;
    logic          we_q,    we_d;

    logic [IW-1:0] g_lo, g_mod;
    logic [CW-1:0] cnt_clamped;
    logic          g_unused;

    assign g_lo     = ls.g[IW-1:0];
    assign g_unused = ^ls.g;

    // g_lo is below 2*NSC, so one conditional subtract gives g mod NSC. When
    // NSC is a power of two the cast constant is 0 and g_lo passes through.
    assign g_mod       = (g_lo >= IW'(NSC)) ? g_lo - IW'(NSC) : g_lo;
    assign cnt_clamped = (ls.count > CW'(NSC)) ? CW'(NSC) : ls.count;

    // State register and latched operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            we_q    <= we_d;
        end
    end

    // Next state: accept in IDLE/DONE, step index and count in RUN.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        we_d    = we_q;
        case (state_q)
            ST_RUN: begin
                idx_d = (idx_q == IW'(NSC - 1)) ? '0 : idx_q + 1'b1;
                rem_d = rem_q - 1'b1;
                if (rem_q == CW'(1)) state_d = ST_DONE;
            end
            default: begin
                if (state_q == ST_DONE) state_d = ST_IDLE;
                if (ls.new_op) begin
                    we_d    = ls.we;
                    rem_d   = cnt_clamped;
                    idx_d   = g_mod;
                    state_d = (ls.count != '0) ? ST_RUN : ST_DONE;
                end
            end
        endcase
    end

    // Decode the upcoming beat so the registered outputs line up with the state.
    logic                  run_d;
    logic [NUM_ELEMS-1:0]  dec_load_en;
    logic [WW-1:0]         dec_sel_word, dec_sel_store_word;
    logic [NUM_SLICES-1:0] dec_serial;

    assign run_d = (state_d == ST_RUN);

    vector_ls_index_decode #(
        .NUM_SLICES  (NUM_SLICES),
        .NUM_ELEMS   (NUM_ELEMS),
        .ELEM_SIZE   (ELEM_SIZE),
        .SCALAR_SIZE (SCALAR_SIZE)
    ) u_decode (
        .idx            (idx_d),
        .we             (we_d),
        .active         (run_d),
        .load_en        (dec_load_en),
        .sel_word       (dec_sel_word),
        .sel_store_word (dec_sel_store_word),
        .serial_output  (dec_serial)
    );

    logic [NUM_ELEMS-1:0]  load_en_q;
    logic [WW-1:0]         sel_word_q, sel_store_word_q;
    logic [NUM_SLICES-1:0] serial_q;
    logic                  complete_q;

    // Output registers; reset clears them immediately so an aborted run goes quiet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_en_q        <= '0;
            sel_word_q       <= '0;
            sel_store_word_q <= '0;
            serial_q         <= '0;
            complete_q       <= 1'b0;
        end else begin
            load_en_q        <= dec_load_en;
            sel_word_q       <= dec_sel_word;
            sel_store_word_q <= dec_sel_store_word;
            serial_q         <= dec_serial;
            complete_q       <= (state_d == ST_DONE);
        end
    end

    assign ls.load_en        = load_en_q;
    assign ls.sel_word       = sel_word_q;
    assign ls.sel_store_word = sel_store_word_q;
    assign ls.serial_output  = serial_q;
    assign ls.complete       = complete_q;

endmodule

// File: tb/tb_vector_ls_sequencer.sv
// Self-checking bench for vector_ls_sequencer with two slices (SPV=4, NSC=8, EPW=2).
module tb_vector_ls_sequencer;

    localparam int NSC = 8;
    localparam int SPV = 4;
    localparam int EPW = 2;

    logic clk;
    logic reset;
    int   errs;
    int   checks;

    Vector_ls_ctrl_if #(.NUM_SLICES(2)) ls_if ();

    vector_ls_sequencer #(.NUM_SLICES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .ls    (ls_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] le, input logic [31:0] so,
                              input logic [31:0] sw, input logic [31:0] ssw, input logic [31:0] c);
        chk({tag, ".load_en"},        32'(ls_if.load_en),        le);
        chk({tag, ".serial_output"},  32'(ls_if.serial_output),  so);
        chk({tag, ".sel_word"},       32'(ls_if.sel_word),       sw);
        chk({tag, ".sel_store_word"}, 32'(ls_if.sel_store_word), ssw);
        chk({tag, ".complete"},       32'(ls_if.complete),       c);
    endtask

    task automatic set_op(input bit we, input int cnt, input logic [31:0] g);
        ls_if.new_op = 1'b1;
        ls_if.we     = we;
        ls_if.count  = 4'(cnt);
        ls_if.g      = g;
    endtask

    // Advance to just after the next rising edge; junk on the idle inputs must be ignored.
    task automatic step();
        @(posedge clk);
        #1;
        ls_if.new_op = 1'b0;
        ls_if.we     = 1'($urandom);
        ls_if.count  = 4'($urandom);
        ls_if.g      = $urandom;
    endtask

    // Reference: beat k touches word (g mod NSC + k) mod NSC, for min(count, NSC) beats,
    // followed by one complete cycle. Returns positioned in the complete cycle.
    task automatic run_beats(input string tag, input bit we, input int cnt, input logic [31:0] g,
                             input int inj);
        int n, base, idx, slice, word;
        logic [31:0] le, sw, ssw;
        n    = (cnt > NSC) ? NSC : cnt;
        base = int'(g % 32'(NSC));
        for (int k = 0; k < n; k++) begin
            idx   = (base + k) % NSC;
            slice = idx / SPV;
            word  = idx % SPV;
            le    = we ? (32'((1 << EPW) - 1) << (word * EPW)) : 32'd0;
            sw    = we ? 32'(word) : 32'd0;
            ssw   = we ? 32'd0 : 32'(word);
            check_outs($sformatf("%s.b%0d", tag, k), le, 32'(1) << slice, sw, ssw, 32'd0);
            if (k == inj) set_op(1'b1, 1, 32'd0);
            step();
        end
        check_outs({tag, ".done"}, 0, 0, 0, 0, 1);
    endtask

    bit          r_we;
    int          r_cnt;
    logic [31:0] r_g;

    initial begin
        errs   = 0;
        checks = 0;
        ls_if.new_op = 1'b0;
        ls_if.we     = 1'b0;
        ls_if.count  = '0;
        ls_if.g      = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #3 check_outs("reset", 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        step();
        check_outs("idle0", 0, 0, 0, 0, 0);

        // Load, beats at words 0..2 of slice 0.
        set_op(1'b1, 3, 32'd0);
        step();
        run_beats("load", 1'b1, 3, 32'd0, -1);
        step();
        check_outs("load.idle", 0, 0, 0, 0, 0);

        // Store wrapping past the last word.
        set_op(1'b0, 4, 32'd6);
        step();
        run_beats("wrap", 1'b0, 4, 32'd6, -1);
        step();
        check_outs("wrap.idle", 0, 0, 0, 0, 0);

        // Zero count: complete right after accept.
        set_op(1'b1, 0, 32'd5);
        step();
        run_beats("zero", 1'b1, 0, 32'd5, -1);
        step();
        check_outs("zero.idle", 0, 0, 0, 0, 0);

        // Clamp to NSC, with a new_op in beat 3 that must be ignored; upper g bits ignored too.
        set_op(1'b1, 12, 32'hABCD_0009);
        step();
        run_beats("clamp", 1'b1, 12, 32'hABCD_0009, 2);
        step();
        check_outs("clamp.idle", 0, 0, 0, 0, 0);

        // Back-to-back: next accept in the DONE cycle.
        set_op(1'b1, 3, 32'd2);
        step();
        run_beats("b2b1", 1'b1, 3, 32'd2, -1);
        set_op(1'b0, 2, 32'd4);
        step();
        run_beats("b2b2", 1'b0, 2, 32'd4, -1);
        step();
        check_outs("b2b.idle", 0, 0, 0, 0, 0);

        // Reset in beat 2 of a five-beat load.
        set_op(1'b1, 5, 32'd0);
        step();
        check_outs("rst.b0", 32'h3, 32'h1, 0, 0, 0);
        step();
        check_outs("rst.b1", 32'hC, 32'h1, 1, 0, 0);
        #2 reset = 1'b0;
        #1 check_outs("rst.async", 0, 0, 0, 0, 0);
        repeat (3) begin
            @(posedge clk);
            #1 chk("rst.hold.complete", 32'(ls_if.complete), 0);
        end
        reset = 1'b1;
        step();
        check_outs("rst.idle", 0, 0, 0, 0, 0);
        set_op(1'b1, 1, 32'd3);
        step();
        run_beats("rst.after", 1'b1, 1, 32'd3, -1);
        step();
        check_outs("rst.after.idle", 0, 0, 0, 0, 0);

        // Random operations, sometimes chained straight from DONE.
        for (int i = 0; i < 40; i++) begin
            r_we  = 1'($urandom_range(0, 1));
            r_cnt = $urandom_range(0, 12);
            r_g   = $urandom;
            set_op(r_we, r_cnt, r_g);
            step();
            run_beats($sformatf("rnd%0d", i), r_we, r_cnt, r_g, -1);
            if ($urandom_range(0, 1) == 1) begin
                step();
                check_outs($sformatf("rnd%0d.idle", i), 0, 0, 0, 0, 0);
            end
        end
        step();
        check_outs("final.idle", 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
